// File: rtl/round_key_xor.sv
// AddRoundKey stage: XORs each accepted state with a stored round key, one register of latency.
// Optional ROUND_KEY_BYPASS_EN forwards a same-cycle key write into the accept that reads that slot.
module round_key_xor #(
    parameter int DATA_W   = 128,
    parameter int NUM_KEYS = 15,
    parameter int IDX_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_wr_en,
    input  logic [IDX_W-1:0]  key_wr_idx,
    input  logic [DATA_W-1:0] key_wr_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_state,
    input  logic [IDX_W-1:0]  in_round,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_state,
    output logic [IDX_W-1:0]  out_round,
    output logic              out_key_miss,
    output logic              wr_err
);

    // One extra bit so the range test also works when NUM_KEYS == 2**IDX_W.
    localparam logic [IDX_W:0] NUM_KEYS_X = (IDX_W + 1)'(NUM_KEYS);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } occ_t;

    occ_t occ_reg;
    occ_t occ_next;

    logic [DATA_W-1:0]   key_reg [NUM_KEYS];
    logic [NUM_KEYS-1:0] loaded_reg;
    logic [NUM_KEYS-1:0] slot_wr;
    logic [NUM_KEYS-1:0] slot_sel;

    logic              wr_in_range;
    logic              rd_in_range;
    logic              accept;
    logic [DATA_W-1:0] key_sel;
    logic              loaded_sel;

    logic [DATA_W-1:0] out_state_reg;
    logic [DATA_W-1:0] out_state_next;
    logic [IDX_W-1:0]  out_round_reg;
    logic              out_key_miss_reg;
    logic              out_key_miss_next;
    logic              wr_err_reg;

    assign wr_in_range = ({1'b0, key_wr_idx} < NUM_KEYS_X);
    assign rd_in_range = ({1'b0, in_round} < NUM_KEYS_X);

    assign in_ready = (occ_reg == EMPTY) || out_ready;
    assign accept   = in_valid && in_ready;

    // Per-slot key register and loaded flag; slot decode is one-hot.
    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_slot
            assign slot_wr[gi]  = key_wr_en && (key_wr_idx == IDX_W'(gi));
            assign slot_sel[gi] = (in_round == IDX_W'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    key_reg[gi]    <= '0;
                    loaded_reg[gi] <= 1'b0;
                end else if (slot_wr[gi]) begin
                    key_reg[gi]    <= key_wr_data;
                    loaded_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Out-of-range rounds select no slot, so the key reads as zero and the slot as unloaded.
    always_comb begin
        key_sel    = '0;
        loaded_sel = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (slot_sel[i]) begin
                key_sel    = key_sel | key_reg[i];
                loaded_sel = loaded_sel | loaded_reg[i];
            end
        end
`ifdef ROUND_KEY_BYPASS_EN
        if (key_wr_en && rd_in_range && (key_wr_idx == in_round)) begin
            key_sel    = key_wr_data;
            loaded_sel = 1'b1;
        end
`endif
    end

    always_comb begin
        out_state_next    = in_state ^ key_sel;
        out_key_miss_next = !loaded_sel || !rd_in_range;
    end

    always_comb begin
        occ_next = occ_reg;
        case (occ_reg)
            EMPTY:   if (accept) occ_next = FULL;
            FULL:    if (out_ready && !accept) occ_next = EMPTY;
            default: occ_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_reg <= EMPTY;
        end else begin
            occ_reg <= occ_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_state_reg    <= '0;
            out_round_reg    <= '0;
            out_key_miss_reg <= 1'b0;
        end else if (accept) begin
            out_state_reg    <= out_state_next;
            out_round_reg    <= in_round;
            out_key_miss_reg <= out_key_miss_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_reg <= 1'b0;
        end else if (key_wr_en && !wr_in_range) begin
            wr_err_reg <= 1'b1;
        end
    end

    assign out_valid    = (occ_reg == FULL);
    assign out_state    = out_state_reg;
    assign out_round    = out_round_reg;
    assign out_key_miss = out_key_miss_reg;
    assign wr_err       = wr_err_reg;

endmodule

// File: tb/tb_round_key_xor.sv
// Scoreboard bench for round_key_xor: driver pushes model results, a negedge monitor pops and compares.
module tb_round_key_xor;

    localparam int DW = 128;
    localparam int NK = 15;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          key_wr_en = 1'b0;
    logic [IW-1:0] key_wr_idx = '0;
    logic [DW-1:0] key_wr_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_state = '0;
    logic [IW-1:0] in_round = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_state;
    logic [IW-1:0] out_round;
    logic          out_key_miss;
    logic          wr_err;

    round_key_xor #(.DATA_W(DW), .NUM_KEYS(NK), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_round(in_round),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .out_round(out_round), .out_key_miss(out_key_miss), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          miss;
        logic [IW-1:0] round;
        logic [DW-1:0] state;
    } exp_t;

    int   compared = 0;
    int   mismatched = 0;
    exp_t sb[$];

    logic [DW-1:0] m_key [NK];
    bit            m_loaded [NK];
    bit            m_wr_err;

    bit   stall_prev = 1'b0;
    exp_t held;

    task automatic chk(input string name, input logic [DW+IW:0] got, input logic [DW+IW:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NK; i++) begin
            m_key[i]    = '0;
            m_loaded[i] = 1'b0;
        end
        m_wr_err = 1'b0;
        sb.delete();
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: the key a round sees is whatever was stored before this edge,
    // or the incoming write when same-slot forwarding is built in.
    function automatic exp_t model_xor(input bit we, input int widx, input logic [DW-1:0] wd,
                                       input logic [DW-1:0] st, input int rd);
        exp_t          e;
        logic [DW-1:0] k;
        bit            ld;
        e.round = IW'(rd);
        if (rd >= NK) begin
            e.state = st;
            e.miss  = 1'b1;
            return e;
        end
        k  = m_key[rd];
        ld = m_loaded[rd];
`ifdef ROUND_KEY_BYPASS_EN
        if (we && widx == rd) begin
            k  = wd;
            ld = 1'b1;
        end
`else
        if (we && widx == rd && wd == '1) k = m_key[rd];
`endif
        e.state = st ^ k;
        e.miss  = !ld;
        return e;
    endfunction

    // Called at posedge+1; returns at the following posedge+1.
    task automatic drive(input bit we, input int widx, input logic [DW-1:0] wd,
                         input bit v, input logic [DW-1:0] st, input int rd, input bit ordy);
        key_wr_en   = we;
        key_wr_idx  = IW'(widx);
        key_wr_data = wd;
        in_valid    = v;
        in_state    = st;
        in_round    = IW'(rd);
        out_ready   = ordy;
        @(negedge clk);
        if (v && in_ready) sb.push_back(model_xor(we, widx, wd, st, rd));
        if (we) begin
            if (widx < NK) begin
                m_key[widx]    = wd;
                m_loaded[widx] = 1'b1;
            end else begin
                m_wr_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        key_wr_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && out_valid)
                chk("hold_stable", {out_key_miss, out_round, out_state}, held);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL sb_underflow: got output %h want none", out_state);
                end else begin
                    chk("result", {out_key_miss, out_round, out_state}, sb.pop_front());
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = {out_key_miss, out_round, out_state};
        end
    end

    logic [DW-1:0] k0, s0, ones, a5, want_bp;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_state", out_state, 0);
        chk("rst_out_round", out_round, 0);
        chk("rst_out_key_miss", out_key_miss, 0);
        chk("rst_wr_err", wr_err, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Slot 0 = 000102..0F, state 00112233..FF.
        for (int b = 0; b < 16; b++) begin
            k0[DW-1-8*b -: 8] = 8'(b);
            s0[DW-1-8*b -: 8] = 8'(b * 17);
        end
        drive(1, 0, k0, 0, '0, 0, 1);
        drive(0, 0, '0, 1, s0, 0, 1);
        chk("vec_out_valid", out_valid, 1);
        chk("vec_out_state", out_state, 128'h00102030405060708090A0B0C0D0E0F0);
        chk("vec_out_miss", out_key_miss, 0);

        // Unloaded slot, then an out-of-range write.
        drive(0, 0, '0, 1, rand_word(), 3, 1);
        chk("unloaded_miss", out_key_miss, 1);
        drive(1, 15, rand_word(), 0, '0, 0, 1);
        chk("wr_err_set", wr_err, 1);
        repeat (3) drive(0, 0, '0, 0, '0, 0, 1);
        chk("wr_err_sticky", wr_err, 1);

        // Same-cycle write and accept to never-loaded slot 2.
        ones = '1;
        a5   = {16{8'hA5}};
        drive(1, 2, ones, 1, a5, 2, 1);
`ifdef ROUND_KEY_BYPASS_EN
        want_bp = {16{8'h5A}};
        chk("same_cycle_miss", out_key_miss, 0);
`else
        want_bp = {16{8'hA5}};
        chk("same_cycle_miss", out_key_miss, 1);
`endif
        chk("same_cycle_state", out_state, want_bp);

        // Load all slots, stream rounds 0..14 back-to-back.
        for (int i = 0; i < NK; i++) drive(1, i, rand_word(), 0, '0, 0, 1);
        for (int r = 0; r < NK; r++) begin
            drive(0, 0, '0, 1, rand_word(), r, 1);
            chk("stream_out_valid", out_valid, 1);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, '0, 1, rand_word(), 0, 0);
            chk("stall_in_ready", in_ready, 0);
        end
        repeat (2) drive(0, 0, '0, 0, '0, 0, 1);

        // Asynchronous reset while a result is held.
        drive(0, 0, '0, 1, rand_word(), 0, 0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_out_state", out_state, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(0, 0, '0, 1, rand_word(), 0, 1);
        chk("post_rst_miss", out_key_miss, 1);
        chk("post_rst_wr_err", wr_err, 0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) == 0, int'($urandom_range(0, 15)), rand_word(),
                  $urandom_range(0, 1) == 1, rand_word(), int'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0);
        end
        repeat (3) drive(0, 0, '0, 0, '0, 0, 1);
        chk("sb_drained", sb.size(), 0);
        chk("final_wr_err", wr_err, m_wr_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
